// File: rtl/axi_burst_master_if.sv
// AXI4 master-side bus for axi_burst_master: AW, W, B, AR and R channels.
// The master modport is used by the burst engine; the slave modport is used by a memory or bus model.
interface axi_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   M_AXI_AWADDR;
    logic [7:0]          M_AXI_AWLEN;
    logic [2:0]          M_AXI_AWSIZE;
    logic [1:0]          M_AXI_AWBURST;
    logic                M_AXI_AWVALID;
    logic                M_AXI_AWREADY;

    logic [DATA_W-1:0]   M_AXI_WDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic                M_AXI_WLAST;
    logic                M_AXI_WVALID;
    logic                M_AXI_WREADY;

    logic [1:0]          M_AXI_BRESP;
    logic                M_AXI_BVALID;
    logic                M_AXI_BREADY;

    logic [ADDR_W-1:0]   M_AXI_ARADDR;
    logic [7:0]          M_AXI_ARLEN;
    logic [2:0]          M_AXI_ARSIZE;
    logic [1:0]          M_AXI_ARBURST;
    logic                M_AXI_ARVALID;
    logic                M_AXI_ARREADY;

    logic [DATA_W-1:0]   M_AXI_RDATA;
    logic [1:0]          M_AXI_RRESP;
    logic                M_AXI_RLAST;
    logic                M_AXI_RVALID;
    logic                M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master.
// A command selects a write burst (data streamed from wr_*) or a read burst (data streamed to rd_*).
// Completion is reported by a one-cycle done pulse with the burst response on resp.
// Optional macro AXI_BURST_MASTER_4K_CHECK_EN rejects bursts that cross a 4 KiB boundary.
// A rejected burst drives no AXI channel and completes with resp = 2'b10.
module axi_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                done,
    output logic [1:0]          resp,
    axi_burst_master_if.master  m_axi
);
    localparam int         STRB_W  = DATA_W / 8;
    localparam logic [2:0] AX_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

    state_t            state, state_next;
    logic              alive;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        cnt;
    logic              aw_valid_q, ar_valid_q;
    logic [1:0]        rresp_max;
    logic              proto_err;
    logic              done_q;
    logic [1:0]        resp_q;

    logic              cmd_fire, reject, w_fire, r_fire;
    logic              beat_is_last, beat_err;
    logic [1:0]        resp_merge;
    logic              finish;
    logic [1:0]        finish_resp;

`ifdef AXI_BURST_MASTER_4K_CHECK_EN
    logic [31:0] end_off;
    assign end_off = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(STRB_W);
    assign reject  = (end_off > 32'd4096);
`else
    assign reject = 1'b0;
`endif

    assign beat_is_last = (cnt == len_q);
    assign beat_err     = (m_axi.M_AXI_RLAST != beat_is_last);
    assign resp_merge   = (m_axi.M_AXI_RRESP > rresp_max) ? m_axi.M_AXI_RRESP : rresp_max;

    // Address channels come straight from flops; fields read as zero whenever the channel is idle.
    assign m_axi.M_AXI_AWVALID = aw_valid_q;
    assign m_axi.M_AXI_AWADDR  = aw_valid_q ? addr_q  : '0;
    assign m_axi.M_AXI_AWLEN   = aw_valid_q ? len_q   : '0;
    assign m_axi.M_AXI_AWSIZE  = aw_valid_q ? AX_SIZE : '0;
    assign m_axi.M_AXI_AWBURST = aw_valid_q ? 2'b01   : '0;
    assign m_axi.M_AXI_ARVALID = ar_valid_q;
    assign m_axi.M_AXI_ARADDR  = ar_valid_q ? addr_q  : '0;
    assign m_axi.M_AXI_ARLEN   = ar_valid_q ? len_q   : '0;
    assign m_axi.M_AXI_ARSIZE  = ar_valid_q ? AX_SIZE : '0;
    assign m_axi.M_AXI_ARBURST = ar_valid_q ? 2'b01   : '0;

    assign done = done_q;
    assign resp = resp_q;

    // State register; reset forces IDLE immediately, abandoning any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the data-stream pass-through for the active state.
    always_comb begin
        state_next         = state;
        cmd_ready          = 1'b0;
        cmd_fire           = 1'b0;
        w_fire             = 1'b0;
        r_fire             = 1'b0;
        finish             = 1'b0;
        finish_resp        = 2'b00;
        wr_ready           = 1'b0;
        rd_valid           = 1'b0;
        rd_data            = '0;
        rd_last            = 1'b0;
        m_axi.M_AXI_WVALID = 1'b0;
        m_axi.M_AXI_WDATA  = '0;
        m_axi.M_AXI_WSTRB  = '0;
        m_axi.M_AXI_WLAST  = 1'b0;
        m_axi.M_AXI_BREADY = 1'b0;
        m_axi.M_AXI_RREADY = 1'b0;
        case (state)
            S_IDLE: begin
                // alive holds cmd_ready low until the first edge after reset release
                cmd_ready = alive;
                cmd_fire  = cmd_valid && alive;
                if (cmd_fire) begin
                    if (reject) begin
                        finish      = 1'b1;
                        finish_resp = 2'b10;
                    end else begin
                        state_next = cmd_write ? S_AW : S_AR;
                    end
                end
            end
            S_AW: begin
                if (m_axi.M_AXI_AWREADY) state_next = S_W;
            end
            S_W: begin
                wr_ready           = m_axi.M_AXI_WREADY;
                m_axi.M_AXI_WVALID = wr_valid;
                m_axi.M_AXI_WDATA  = wr_data;
                m_axi.M_AXI_WSTRB  = wr_strb;
                m_axi.M_AXI_WLAST  = beat_is_last;
                w_fire             = wr_valid && m_axi.M_AXI_WREADY;
                if (w_fire && beat_is_last) state_next = S_B;
            end
            S_B: begin
                m_axi.M_AXI_BREADY = 1'b1;
                if (m_axi.M_AXI_BVALID) begin
                    state_next  = S_IDLE;
                    finish      = 1'b1;
                    finish_resp = m_axi.M_AXI_BRESP;
                end
            end
            S_AR: begin
                if (m_axi.M_AXI_ARREADY) state_next = S_R;
            end
            S_R: begin
                rd_valid           = m_axi.M_AXI_RVALID;
                rd_data            = m_axi.M_AXI_RDATA;
                rd_last            = m_axi.M_AXI_RLAST;
                m_axi.M_AXI_RREADY = rd_ready;
                r_fire             = m_axi.M_AXI_RVALID && rd_ready;
                if (r_fire && m_axi.M_AXI_RLAST) begin
                    state_next  = S_IDLE;
                    finish      = 1'b1;
                    finish_resp = (proto_err || beat_err) ? 2'b10 : resp_merge;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Command capture, beat counting, read-response accumulation and the registered completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive      <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt        <= '0;
            aw_valid_q <= 1'b0;
            ar_valid_q <= 1'b0;
            rresp_max  <= '0;
            proto_err  <= 1'b0;
            done_q     <= 1'b0;
            resp_q     <= '0;
        end else begin
            alive      <= 1'b1;
            aw_valid_q <= (state_next == S_AW);
            ar_valid_q <= (state_next == S_AR);
            done_q     <= finish;
            if (finish) resp_q <= finish_resp;
            if (cmd_fire) begin
                addr_q    <= cmd_addr;
                len_q     <= cmd_len;
                cnt       <= '0;
                rresp_max <= '0;
                proto_err <= 1'b0;
            end else if (w_fire) begin
                cnt <= cnt + 8'd1;
            end else if (r_fire) begin
                cnt       <= cnt + 8'd1;
                rresp_max <= resp_merge;
                if (beat_err) proto_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: write/read bursts, response merging, RLAST protocol
// errors, AW back-pressure, 4 KiB boundary handling (AXI_BURST_MASTER_4K_CHECK_EN) and mid-burst reset.
module tb_axi_burst_master;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done;
    logic [1:0]  resp;

    int checks   = 0;
    int failures = 0;

    axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_axi ();

    axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .done      (done),
        .resp      (resp),
        .m_axi     (m_axi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input int len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        #1;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cyc();
        cmd_valid = 1'b0;
    endtask

    // Hold AWREADY low for 'stall' cycles with write data already offered, then handshake.
    task automatic aw_phase(input logic [31:0] addr, input int len, input int stall);
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        m_axi.M_AXI_AWREADY = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            check("aw_stall_valid", 64'(m_axi.M_AXI_AWVALID), 64'd1);
            check("aw_stall_addr",  64'(m_axi.M_AXI_AWADDR),  64'(addr));
            check("aw_stall_len",   64'(m_axi.M_AXI_AWLEN),   64'(len));
            check("aw_stall_wvalid", 64'(m_axi.M_AXI_WVALID) | 64'(wr_ready), 64'd0);
            cyc();
        end
        m_axi.M_AXI_AWREADY = 1'b1;
        #1;
        check("aw_valid", 64'(m_axi.M_AXI_AWVALID), 64'd1);
        check("aw_addr",  64'(m_axi.M_AXI_AWADDR),  64'(addr));
        check("aw_len",   64'(m_axi.M_AXI_AWLEN),   64'(len));
        check("aw_size",  64'(m_axi.M_AXI_AWSIZE),  64'd2);
        check("aw_burst", 64'(m_axi.M_AXI_AWBURST), 64'd1);
        check("aw_no_w",  64'(m_axi.M_AXI_WVALID),  64'd0);
        check("aw_cmd_ready", 64'(cmd_ready), 64'd0);
        cyc();
        m_axi.M_AXI_AWREADY = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] addr, input int len);
        m_axi.M_AXI_ARREADY = 1'b1;
        m_axi.M_AXI_RVALID  = 1'b1;
        #1;
        check("ar_valid", 64'(m_axi.M_AXI_ARVALID), 64'd1);
        check("ar_addr",  64'(m_axi.M_AXI_ARADDR),  64'(addr));
        check("ar_len",   64'(m_axi.M_AXI_ARLEN),   64'(len));
        check("ar_size",  64'(m_axi.M_AXI_ARSIZE),  64'd2);
        check("ar_burst", 64'(m_axi.M_AXI_ARBURST), 64'd1);
        check("ar_no_aw", 64'(m_axi.M_AXI_AWVALID), 64'd0);
        check("ar_no_r",  64'(rd_valid) | 64'(m_axi.M_AXI_RREADY), 64'd0);
        cyc();
        m_axi.M_AXI_ARREADY = 1'b0;
        m_axi.M_AXI_RVALID  = 1'b0;
    endtask

    // W beats (optionally with WREADY toggling) then the B response.
    task automatic wr_run(input int len, input logic toggle, input logic [1:0] bresp);
        int b = 0;
        int c = 0;
        while (b <= len && c < 600) begin
            m_axi.M_AXI_WREADY = toggle ? logic'(c % 2) : 1'b1;
            wr_valid = 1'b1;
            wr_data  = 32'hA500_0000 + 32'(b);
            wr_strb  = 4'(b) | 4'h1;
            #1;
            check("w_valid", 64'(m_axi.M_AXI_WVALID), 64'd1);
            check("w_data",  64'(m_axi.M_AXI_WDATA),  64'(32'hA500_0000 + 32'(b)));
            check("w_strb",  64'(m_axi.M_AXI_WSTRB),  64'(4'(b) | 4'h1));
            check("w_last",  64'(m_axi.M_AXI_WLAST),  64'(b == len));
            check("wr_ready", 64'(wr_ready), 64'(m_axi.M_AXI_WREADY));
            if (m_axi.M_AXI_WREADY) b++;
            cyc();
            c++;
        end
        if (c >= 600) check("w_timeout", 64'd0, 64'd1);
        wr_valid = 1'b0;
        m_axi.M_AXI_WREADY = 1'b0;
        #1;
        check("b_ready", 64'(m_axi.M_AXI_BREADY), 64'd1);
        check("b_no_w",  64'(m_axi.M_AXI_WVALID), 64'd0);
        check("b_no_done", 64'(done), 64'd0);
        cyc();
        m_axi.M_AXI_BVALID = 1'b1;
        m_axi.M_AXI_BRESP  = bresp;
        cyc();
        m_axi.M_AXI_BVALID = 1'b0;
        m_axi.M_AXI_BRESP  = 2'b00;
        #1;
        check("wr_done", 64'(done), 64'd1);
        check("wr_resp", 64'(resp), 64'(bresp));
        check("wr_done_cmd_ready", 64'(cmd_ready), 64'd1);
        check("wr_done_bready", 64'(m_axi.M_AXI_BREADY), 64'd0);
        cyc();
        check("wr_done_pulse", 64'(done), 64'd0);
    endtask

    // R beats from a slave that asserts RLAST on beat 'last_beat'; beat 'err_beat' carries err_resp.
    task automatic rd_run(input int len, input int last_beat, input int err_beat,
                          input logic [1:0] err_resp, input logic toggle, input logic [1:0] exp_resp);
        int k = 0;
        int c = 0;
        while (k <= last_beat && c < 600) begin
            rd_ready = toggle ? logic'(c % 2) : 1'b1;
            m_axi.M_AXI_RVALID = 1'b1;
            m_axi.M_AXI_RDATA  = 32'h0000_1100 + 32'(k);
            m_axi.M_AXI_RRESP  = (k == err_beat) ? err_resp : 2'b00;
            m_axi.M_AXI_RLAST  = (k == last_beat);
            #1;
            check("rd_valid", 64'(rd_valid), 64'd1);
            check("rd_data",  64'(rd_data),  64'(32'h0000_1100 + 32'(k)));
            check("rd_last",  64'(rd_last),  64'(k == last_beat));
            check("r_ready",  64'(m_axi.M_AXI_RREADY), 64'(rd_ready));
            if (rd_ready) k++;
            cyc();
            c++;
        end
        m_axi.M_AXI_RVALID = 1'b0;
        m_axi.M_AXI_RLAST  = 1'b0;
        m_axi.M_AXI_RRESP  = 2'b00;
        rd_ready = 1'b0;
        #1;
        check("rd_beats", 64'(k), 64'(last_beat + 1));
        check("rd_done",  64'(done), 64'd1);
        check("rd_resp",  64'(resp), 64'(exp_resp));
        check("rd_done_cmd_ready", 64'(cmd_ready), 64'd1);
        cyc();
        check("rd_done_pulse", 64'(done), 64'd0);
        if (len < 0) check("rd_len_arg", 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        m_axi.M_AXI_AWREADY = 1'b0; m_axi.M_AXI_WREADY = 1'b0;
        m_axi.M_AXI_BRESP = 2'b00;  m_axi.M_AXI_BVALID = 1'b0;
        m_axi.M_AXI_ARREADY = 1'b0; m_axi.M_AXI_RDATA = '0; m_axi.M_AXI_RRESP = 2'b00;
        m_axi.M_AXI_RLAST = 1'b0;   m_axi.M_AXI_RVALID = 1'b0;

        // Reset state
        repeat (3) cyc();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_axvalid", 64'(m_axi.M_AXI_AWVALID) | 64'(m_axi.M_AXI_ARVALID), 64'd0);
        check("rst_ready_out", 64'(m_axi.M_AXI_BREADY) | 64'(m_axi.M_AXI_RREADY) | 64'(wr_ready), 64'd0);
        check("rst_awsize", 64'(m_axi.M_AXI_AWSIZE), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_cmd_ready_pre_edge", 64'(cmd_ready), 64'd0);
        cyc();
        check("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rel_done", 64'(done), 64'd0);

        // Write 0x1000 len 3, immediate AWREADY, WREADY high, OKAY
        issue(1'b1, 32'h0000_1000, 3);
        aw_phase(32'h0000_1000, 3, 0);
        wr_run(3, 1'b0, 2'b00);

        // Read 0x2000 len 7, SLVERR on beat 4, rd_ready toggling
        issue(1'b0, 32'h0000_2000, 7);
        ar_phase(32'h0000_2000, 7);
        rd_run(7, 7, 4, 2'b10, 1'b1, 2'b10);

        // Read response is the maximum RRESP when RLAST is well-formed
        issue(1'b0, 32'h0000_2100, 2);
        ar_phase(32'h0000_2100, 2);
        rd_run(2, 2, 1, 2'b01, 1'b0, 2'b01);

        // Early RLAST on beat 1 of len 3
        issue(1'b0, 32'h0000_2200, 3);
        ar_phase(32'h0000_2200, 3);
        rd_run(3, 1, -1, 2'b00, 1'b0, 2'b10);

        // Missing RLAST on final beat of len 1; slave ends on beat 2
        issue(1'b0, 32'h0000_2300, 1);
        ar_phase(32'h0000_2300, 1);
        rd_run(1, 2, -1, 2'b00, 1'b0, 2'b10);

        // AWREADY held low 10 cycles, then WREADY toggling, EXOKAY response
        issue(1'b1, 32'h0000_3450, 5);
        aw_phase(32'h0000_3450, 5, 10);
        wr_run(5, 1'b1, 2'b01);

        // Burst ending exactly on the 4 KiB boundary is always issued
        issue(1'b1, 32'h0000_0FF0, 3);
        aw_phase(32'h0000_0FF0, 3, 0);
        wr_run(3, 1'b0, 2'b00);

        // Burst crossing the 4 KiB boundary
`ifdef AXI_BURST_MASTER_4K_CHECK_EN
        issue(1'b1, 32'h0000_0FF8, 3);
        check("x4k_no_awvalid", 64'(m_axi.M_AXI_AWVALID), 64'd0);
        check("x4k_wr_ready", 64'(wr_ready), 64'd0);
        check("x4k_done", 64'(done), 64'd1);
        check("x4k_resp", 64'(resp), 64'd2);
        check("x4k_cmd_ready", 64'(cmd_ready), 64'd1);
        cyc();
        check("x4k_done_pulse", 64'(done), 64'd0);
        check("x4k_still_no_aw", 64'(m_axi.M_AXI_AWVALID), 64'd0);
`else
        issue(1'b1, 32'h0000_0FF8, 3);
        aw_phase(32'h0000_0FF8, 3, 0);
        wr_run(3, 1'b0, 2'b00);
`endif

        // Reset during W beat 2 of len 7
        issue(1'b1, 32'h0000_4000, 7);
        aw_phase(32'h0000_4000, 7, 0);
        m_axi.M_AXI_WREADY = 1'b1;
        for (int b = 0; b < 2; b++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h0000_7700 + 32'(b);
            cyc();
        end
        wr_data = 32'h0000_7702;
        #1;
        check("mid_w_valid", 64'(m_axi.M_AXI_WVALID), 64'd1);
        check("mid_w_last", 64'(m_axi.M_AXI_WLAST), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wvalid", 64'(m_axi.M_AXI_WVALID), 64'd0);
        check("mid_rst_wr_ready", 64'(wr_ready), 64'd0);
        check("mid_rst_axvalid", 64'(m_axi.M_AXI_AWVALID) | 64'(m_axi.M_AXI_ARVALID), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        cyc();
        check("mid_rst_done_hold", 64'(done), 64'd0);
        rst_n = 1'b1;
        wr_valid = 1'b0;
        m_axi.M_AXI_WREADY = 1'b0;
        cyc();
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_rst_done", 64'(done), 64'd0);
        issue(1'b0, 32'h0000_5000, 0);
        ar_phase(32'h0000_5000, 0);
        rd_run(0, 0, -1, 2'b00, 1'b0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 ADDR_W, 32, AXI address width.
REQ-002 DATA_W, 32, data width, power of two 32..1024; strobe width DATA_W/8.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-007 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  input  ADDR_W  burst start address.
REQ-009 cmd_len  input  8  beats minus one (0..255).
REQ-010 wr_data / wr_strb / wr_valid / wr_ready  in / in / in / out  DATA_W / DATA_W/8 / 1 / 1  write-data stream.
REQ-011 rd_data / rd_last / rd_valid / rd_ready  out / out / out / in  DATA_W / 1 / 1 / 1  read-data stream.
REQ-012 done / resp  output  1 / 2  one-cycle completion pulse and burst response.
REQ-013 M_AXI_AW{ADDR[ADDR_W],LEN[8],SIZE[3],BURST[2],VALID} out, M_AXI_AWREADY in.
REQ-014 M_AXI_W{DATA[DATA_W],STRB[DATA_W/8],LAST,VALID} out, M_AXI_WREADY in.
REQ-015 M_AXI_B{RESP[2],VALID} in, M_AXI_BREADY out.
REQ-016 M_AXI_AR{ADDR,LEN,SIZE,BURST,VALID} out (widths as AW), M_AXI_ARREADY in.
REQ-017 M_AXI_R{DATA[DATA_W],RESP[2],LAST,VALID} in, M_AXI_RREADY out.

Function
REQ-018 FSM states SHALL be IDLE, AW, W, B, AR, R; one outstanding burst at a time.
REQ-019 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, capture addr/len/write and go to AW (write) or AR (read) next cycle.
REQ-020 In AW/AR: AxVALID=1 (registered), AxADDR=captured addr unchanged, AxLEN=cmd_len, AxSIZE=log2(DATA_W/8), AxBURST=2'b01; all held stable until AxREADY; handshake moves to W or R.
REQ-021 In W: M_AXI_WVALID=wr_valid, wr_ready=M_AXI_WREADY, WDATA/WSTRB=wr_data/wr_strb; 8-bit beat counter from 0; WLAST=1 iff counter==len; last-beat handshake moves to B.
REQ-022 Outside W, wr_ready and M_AXI_WVALID SHALL be 0; outside R, rd_valid and M_AXI_RREADY SHALL be 0.
REQ-023 In B: BREADY=1; on BVALID capture BRESP, go to IDLE, pulse done with resp=BRESP.
REQ-024 In R: rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA, rd_last=RLAST; resp = maximum RRESP over all beats.
REQ-025 RLAST before counter==len, or counter==len beat without RLAST, SHALL force resp=2'b10; completion still occurs only on RLAST handshake.
REQ-026 done SHALL be registered, asserted in the first IDLE cycle after the final handshake; cmd_ready is also 1 in that cycle (back-to-back accept allowed).

Reset
REQ-027 While rst_n=0: state IDLE, all outputs 0 including cmd_ready and done; cmd_ready rises at first clk edge after release.
REQ-028 Reset mid-burst SHALL drop all VALID/READY outputs immediately, without a done pulse; the AXI transaction is abandoned.

Configuration
REQ-029 Macro AXI_BURST_MASTER_4K_CHECK_EN defined: at acceptance, if cmd_addr[11:0] + (cmd_len+1)*(DATA_W/8) > 4096, no AXI channel is driven, wr_ready stays 0, done pulses the next cycle with resp=2'b10.
REQ-030 Macro undefined: every command issues unchanged; no boundary check logic present.

Verification
REQ-031 Write, addr 0x1000, len 3, AWREADY immediate, WREADY always 1, BRESP=0 -> 4 W beats, WLAST on beat 3, done with resp=0.
REQ-032 Read, addr 0x2000, len 7, RRESP=2'b10 on beat 4, rd_ready toggling -> 8 rd beats, no data lost, resp=2'b10.
REQ-033 Read, len 3, slave asserts RLAST on beat 1 -> completion after beat 1, resp=2'b10.
REQ-034 AWREADY held low 10 cycles, AWADDR/AWLEN watched -> AW signals stable, no W beat before AW handshake.
REQ-035 With macro, DATA_W=32, addr 0x0FF8, len 3 -> no AWVALID, done with resp=2'b10; without macro -> burst issued.
REQ-036 rst_n low during W beat 2 of len 7 -> all VALIDs 0 same cycle, no done; new command accepted after release.
